// File: rtl/pipe_delay_chain.sv
// -----------------------------------------------------------------------------
// pipe_delay_chain
//   Parametrised N-stage pipeline register with bypass. It aligns operands and
//   results in the DSP48A1 datapath. Each stage holds a WIDTH-bit data word and
//   a valid bit. All stages share one clock enable. A synchronous flush clears
//   the pipe. A registered count tracks how many stages hold valid words.
//   DEPTH=0 turns the block into a plain combinational wire-through.
//
// Parameters
//   WIDTH      data width per stage (>=1)
//   DEPTH      number of register stages, 0..16 (0 = combinational bypass)
//   FLUSH_DATA 1: flush also zeroes stage data; 0: flush clears valid bits only
//   OCC_W      occupancy width, 2**OCC_W must exceed DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears data, valids, count)
//   ce         clock enable; 0 freezes every stage and the count
//   flush      synchronous flush, only acts when ce=1
//   in_valid   valid for in_data
//   in_data    data into stage 0
//   out_valid  valid bit of the last stage
//   out_data   data word of the last stage
//   occupancy  number of stages whose valid bit is set
// -----------------------------------------------------------------------------
module pipe_delay_chain #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 2,
    parameter int FLUSH_DATA = 0,
    parameter int OCC_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (DEPTH < 0 || DEPTH > 16 || WIDTH < 1 || (2 ** OCC_W) <= DEPTH) begin : g_param_err
        $error("pipe_delay_chain: illegal parameters (DEPTH 0..16, WIDTH>=1, 2**OCC_W>DEPTH)");
    end

    if (DEPTH == 0) begin : g_bypass

        // Pure wire-through: the clock, reset and control inputs have no effect.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, ce, flush};

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign occupancy = '0;

    end else begin : g_pipe

        logic [WIDTH-1:0] data_p [DEPTH];
        logic [DEPTH-1:0] vld_p;
        logic [OCC_W-1:0] occ_p;

        // The word leaving the last stage is replaced by the word entering
        // stage 0, so the count moves by at most one per edge. It stays equal
        // to the popcount of vld_p and can never wrap.
        function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                      input logic              vin,
                                                      input logic              vout);
            return occ + OCC_W'(vin) - OCC_W'(vout);
        endfunction

        // ---- stage registers: shift on every enabled edge ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_p[k] <= '0;
                end
                vld_p <= '0;
                occ_p <= '0;
            end else if (ce) begin
                if (flush) begin
                    // The incoming word is dropped along with every in-flight valid.
                    vld_p <= '0;
                    occ_p <= '0;
                    if (FLUSH_DATA != 0) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            data_p[k] <= '0;
                        end
                    end else begin
                        for (int k = DEPTH - 1; k > 0; k--) begin
                            data_p[k] <= data_p[k-1];
                        end
                        data_p[0] <= in_data;
                    end
                end else begin
                    // Invalid words still move through the pipe, with valid=0.
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        data_p[k] <= data_p[k-1];
                    end
                    data_p[0] <= in_data;
                    vld_p     <= (vld_p << 1) | DEPTH'(in_valid);
                    occ_p     <= occ_next(occ_p, in_valid, vld_p[DEPTH-1]);
                end
            end
        end

        // ---- output: last stage ----
        assign out_valid = vld_p[DEPTH-1];
        assign out_data  = data_p[DEPTH-1];
        assign occupancy = occ_p;

    end

endmodule

// File: tb/tb_pipe_delay_chain.sv
`timescale 1ns/100ps
module tb_pipe_delay_chain;

    localparam int W  = 18;
    localparam int OW = 5;
    localparam int NI = 5;

    // Instance indices
    localparam int I3  = 0;  // DEPTH=3, FLUSH_DATA=0
    localparam int I4F = 1;  // DEPTH=4, FLUSH_DATA=1
    localparam int I4  = 2;  // DEPTH=4, FLUSH_DATA=0
    localparam int I2  = 3;  // DEPTH=2, FLUSH_DATA=0
    localparam int I0  = 4;  // DEPTH=0 (bypass)

    function automatic int dep(input int i);
        case (i)
            I3:      return 3;
            I4F:     return 4;
            I4:      return 4;
            I2:      return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit fd(input int i);
        return (i == I4F);
    endfunction

    logic          clk = 1'b0;
    logic          clk_run = 1'b1;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;

    logic          o_v [NI];
    logic [W-1:0]  o_d [NI];
    logic [OW-1:0] o_o [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 if (clk_run) clk = ~clk;

    pipe_delay_chain #(.WIDTH(W), .DEPTH(3), .FLUSH_DATA(0), .OCC_W(OW)) u_d3 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_v[I3]), .out_data(o_d[I3]), .occupancy(o_o[I3]));
    pipe_delay_chain #(.WIDTH(W), .DEPTH(4), .FLUSH_DATA(1), .OCC_W(OW)) u_d4f (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_v[I4F]), .out_data(o_d[I4F]), .occupancy(o_o[I4F]));
    pipe_delay_chain #(.WIDTH(W), .DEPTH(4), .FLUSH_DATA(0), .OCC_W(OW)) u_d4 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_v[I4]), .out_data(o_d[I4]), .occupancy(o_o[I4]));
    pipe_delay_chain #(.WIDTH(W), .DEPTH(2), .FLUSH_DATA(0), .OCC_W(OW)) u_d2 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_v[I2]), .out_data(o_d[I2]), .occupancy(o_o[I2]));
    pipe_delay_chain #(.WIDTH(W), .DEPTH(0), .FLUSH_DATA(0), .OCC_W(OW)) u_d0 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_v[I0]), .out_data(o_d[I0]), .occupancy(o_o[I0]));

    // Behavioural model: each instance is a row of DEPTH (valid, data) slots.
    logic          m_v [NI][16];
    logic [W-1:0]  m_d [NI][16];

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < NI; i++)
                for (int k = 0; k < 16; k++) begin
                    m_v[i][k] = 1'b0;
                    m_d[i][k] = '0;
                end
        end else if (ce) begin
            for (int i = 0; i < NI; i++) begin
                if (dep(i) > 0) begin
                    for (int k = dep(i) - 1; k > 0; k--) begin
                        m_v[i][k] = m_v[i][k-1];
                        m_d[i][k] = m_d[i][k-1];
                    end
                    m_v[i][0] = in_valid;
                    m_d[i][0] = in_data;
                    if (flush) begin
                        for (int k = 0; k < dep(i); k++) begin
                            m_v[i][k] = 1'b0;
                            if (fd(i)) m_d[i][k] = '0;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic exp_v(input int i);
        if (dep(i) == 0) return in_valid;
        return m_v[i][dep(i)-1];
    endfunction

    function automatic logic [W-1:0] exp_d(input int i);
        if (dep(i) == 0) return in_data;
        return m_d[i][dep(i)-1];
    endfunction

    function automatic int exp_occ(input int i);
        int c = 0;
        for (int k = 0; k < dep(i); k++) c += int'(m_v[i][k]);
        return c;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check("out_valid", i, 32'(o_v[i]), 32'(exp_v(i)));
            check("out_data",  i, 32'(o_d[i]), 32'(exp_d(i)));
            check("occupancy", i, 32'(o_o[i]), 32'(exp_occ(i)));
        end
    endtask

    // Model update and per-cycle comparison
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
            if (clk) begin
                #3;
                check_all();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    logic [W-1:0] sbq [$];

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_valid", I3,  32'(o_v[I3]),  0);
        check("rst_occ",   I3,  32'(o_o[I3]),  0);
        check("rst_data",  I4F, 32'(o_d[I4F]), 0);
        #1 rst = 1'b0;
        ce = 1'b1;

        // T1: three valid words through DEPTH=3
        in_valid = 1'b1; in_data = 'h11; tick();
        check("t1_occ1", I3, 32'(o_o[I3]), 1);
        in_data = 'h22; tick();
        check("t1_occ2", I3, 32'(o_o[I3]), 2);
        in_data = 'h33; tick();
        check("t1_occ3", I3, 32'(o_o[I3]), 3);
        check("t1_v3",   I3, 32'(o_v[I3]), 1);
        check("t1_d3",   I3, 32'(o_d[I3]), 'h11);
        in_valid = 1'b0; in_data = '0; tick();
        check("t1_d4", I3, 32'(o_d[I3]), 'h22);
        tick();
        check("t1_d5", I3, 32'(o_d[I3]), 'h33);
        check("t1_v5", I3, 32'(o_v[I3]), 1);
        repeat (3) tick();

        // T2: freeze with ce=0; in_valid and flush are ignored while frozen
        in_valid = 1'b1; in_data = 'hAA; tick();
        ce = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = W'($urandom); flush = 1'b1;
            tick();
            check("t2_frz_v", I3, 32'(o_v[I3]), 0);
            check("t2_frz_o", I3, 32'(o_o[I3]), 1);
        end
        ce = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        check("t2_e1_v", I3, 32'(o_v[I3]), 0);
        tick();
        check("t2_e2_v", I3, 32'(o_v[I3]), 1);
        check("t2_e2_d", I3, 32'(o_d[I3]), 'hAA);
        repeat (2) tick();

        // T3: fill DEPTH=4 then flush with a valid word arriving
        for (int c = 1; c <= 4; c++) begin
            in_valid = 1'b1; in_data = W'(c); tick();
        end
        check("t3_full_o", I4, 32'(o_o[I4]), 4);
        check("t3_full_d", I4, 32'(o_d[I4]), 1);
        flush = 1'b1; in_valid = 1'b1; in_data = 'h99; tick();
        check("t3_fl_v",  I4,  32'(o_v[I4]),  0);
        check("t3_fl_o",  I4,  32'(o_o[I4]),  0);
        check("t3_fl_d",  I4,  32'(o_d[I4]),  2);
        check("t3_flz_v", I4F, 32'(o_v[I4F]), 0);
        check("t3_flz_o", I4F, 32'(o_o[I4F]), 0);
        check("t3_flz_d", I4F, 32'(o_d[I4F]), 0);
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        check("t3_after_o", I4, 32'(o_o[I4]), 0);
        repeat (3) tick();

        // T4: asynchronous reset between edges with DEPTH=2 full
        in_valid = 1'b1; in_data = 'h7; tick();
        in_data = 'h8; tick();
        check("t4_full_o", I2, 32'(o_o[I2]), 2);
        check("t4_full_d", I2, 32'(o_d[I2]), 'h7);
        rst = 1'b1;
        #0.5;
        check("t4_rst_v", I2, 32'(o_v[I2]), 0);
        check("t4_rst_d", I2, 32'(o_d[I2]), 0);
        check("t4_rst_o", I2, 32'(o_o[I2]), 0);
        in_valid = 1'b1; in_data = 'h3;
        tick();
        check("t4_hold_v", I2, 32'(o_v[I2]), 0);
        check("t4_hold_o", I2, 32'(o_o[I2]), 0);
        rst = 1'b0; in_valid = 1'b1; in_data = 'h5; tick();
        in_valid = 1'b0; in_data = '0; tick();
        check("t4_out_v", I2, 32'(o_v[I2]), 1);
        check("t4_out_d", I2, 32'(o_d[I2]), 'h5);
        repeat (3) tick();

        // T5: clock stopped; DEPTH=0 follows inputs, others hold
        clk_run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin in_valid = 1'b1; in_data = 'h3FFFF; ce = 1'b0; flush = 1'b1; end
                1: begin in_valid = 1'b0; in_data = 'h12345; ce = 1'b1; flush = 1'b0; end
                2: begin in_valid = 1'b1; in_data = 'h00000; ce = 1'b1; flush = 1'b1; end
                default: begin in_valid = 1'b0; in_data = 'h2AAAA; ce = 1'b0; flush = 1'b0; end
            endcase
            #1;
            check("t5_byp_v", I0, 32'(o_v[I0]), (c == 0 || c == 2) ? 1 : 0);
            check("t5_byp_d", I0, 32'(o_d[I0]), (c == 0) ? 'h3FFFF : (c == 1) ? 'h12345 :
                                               (c == 2) ? 'h00000 : 'h2AAAA);
            check("t5_byp_o", I0, 32'(o_o[I0]), 0);
            check_all();
        end
        ce = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        #1 clk_run = 1'b1;
        repeat (4) tick();

        // T6: alternating valids through DEPTH=3 with a scoreboard
        for (int e = 0; e < 16; e++) begin
            in_valid = (e < 12) && (e % 2 == 0);
            in_data  = W'($urandom);
            if (in_valid) sbq.push_back(in_data);
            tick();
            if (o_v[I3]) begin
                check("t6_sb_pending", I3, 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) check("t6_sb_data", I3, 32'(o_d[I3]), 32'(sbq.pop_front()));
            end
            if (e < 12)
                check("t6_occ_range", I3, 32'((o_o[I3] >= 1) && (o_o[I3] <= 2)), 1);
        end
        check("t6_sb_left", I3, 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
